// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Multi-cycle data-memory responder; stalls the requestor for
//               LATENCY cycles, then completes one read or write with Done.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        Err
);

    localparam int         c_DEPTH    = 2 ** ADDR_BITS;
    localparam logic [7:0] c_CNT_INIT = 8'(LATENCY - 1);
    localparam logic       c_SINGLE   = (LATENCY == 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]           r_state;
    logic [0:0]           w_state_next;
    logic [7:0]           r_cnt;
    logic                 r_op_wr;
    logic [ADDR_BITS-1:0] r_idx;
    logic [15:0]          r_wdata;
    logic [15:0]          r_dout;
    logic                 r_err;
    logic [15:0]          r_mem [c_DEPTH];

    logic                 w_legal;
    logic                 w_illegal;
    logic                 w_accept;
    logic                 w_cnt_zero;
    logic                 w_commit;
    logic                 w_load_dout;
    logic [ADDR_BITS-1:0] w_idx;
    logic [ADDR_BITS-1:0] w_rd_idx;

    assign w_legal    = (Rd ^ Wr) & ~Addr[0];
    assign w_illegal  = (Rd | Wr) & ~w_legal;
    assign w_idx      = Addr[ADDR_BITS:1];
    assign w_cnt_zero = (r_cnt == 8'd0);
    assign w_accept   = (r_state == c_IDLE) & w_legal;

    // Address bits above the array size are deliberately ignored (wrap).
    generate
        if (ADDR_BITS < 15) begin : g_unused
            logic w_unused_addr;
            assign w_unused_addr = ^Addr[15:ADDR_BITS+1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_legal)    w_state_next = c_BUSY;
            c_BUSY:  if (w_cnt_zero) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // DataOut is loaded on the edge that enters the Done cycle, so it is
    // already valid while Done is high.
    always_comb begin
        Done        = 1'b0;
        Stall       = 1'b0;
        w_commit    = 1'b0;
        w_load_dout = 1'b0;
        w_rd_idx    = r_idx;
        case (r_state)
            c_IDLE: begin
                Stall = w_legal;
                if (c_SINGLE && w_legal && Rd) begin
                    w_load_dout = 1'b1;
                    w_rd_idx    = w_idx;
                end
            end
            c_BUSY: begin
                Done        = w_cnt_zero;
                Stall       = ~w_cnt_zero;
                w_commit    = w_cnt_zero & r_op_wr & ~rst;
                w_load_dout = (r_cnt == 8'd1) & ~r_op_wr;
            end
            default: begin
                Done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 8'd0;
            r_op_wr <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 16'd0;
            r_dout  <= 16'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == c_IDLE) & w_illegal;
            if (w_accept) begin
                r_cnt   <= c_CNT_INIT;
                r_op_wr <= Wr;
                r_idx   <= w_idx;
                r_wdata <= DataIn;
            end else if ((r_state == c_BUSY) && !w_cnt_zero) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_load_dout) begin
                r_dout <= r_mem[w_rd_idx];
            end
        end
    end

    // Array contents survive reset; only a completed write changes them.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign DataOut = r_dout;
    assign Err     = r_err;

endmodule
`default_nettype wire
